board_arbiter: RTL and testbench
================================

BOARD_ARBITER -- requirements
Module: board_arbiter

Interface
REQ-001 The block SHALL have parameter NCOL, default 8, meaning the number of column units served.
REQ-002 The block SHALL have parameter W, default 160, meaning the width of one column FIFO word.
REQ-003 The block SHALL have parameter CLR_CYCLES, default 2, meaning the number of cycles colReset is held after start.
REQ-004 The block SHALL have parameter TIMEOUT, default 1023, meaning the GEN-state watchdog limit in cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: begin move generation for a loaded board.
REQ-008 The block SHALL have port colDone, input, NCOL bits: per-column done flags.
REQ-009 The block SHALL have port colEmpty, input, NCOL bits: per-column FIFO empty flags.
REQ-010 The block SHALL have port colData, input, NCOL*W bits: column c occupies bits [c*W+W-1 : c*W].
REQ-011 The block SHALL have port colRden, output, NCOL bits: one-hot column FIFO read enables.
REQ-012 The block SHALL have port colReset, output, 1 bit: reset to all column units.
REQ-013 The block SHALL have port outValid, output, 1 bit: outData holds a move.
REQ-014 The block SHALL have port outReady, input, 1 bit: the downstream consumer accepts outData.
REQ-015 The block SHALL have port outData, output, W bits: the move word.
REQ-016 The block SHALL have port moveCount, output, 8 bits: moves emitted since start.
REQ-017 The block SHALL have port busy, output, 1 bit: high in every state except IDLE and FIN.
REQ-018 The block SHALL have port done, output, 1 bit: high in FIN.
REQ-019 The block SHALL have port error, output, 1 bit: watchdog expired.

Function
REQ-020 The state machine SHALL have the states IDLE, CLEAR, GEN, SEL, READ, OUT and FIN.
REQ-021 IDLE and FIN: start=1 SHALL go to CLEAR, clear moveCount and error, and load rrPtr=0; start SHALL be ignored in every other state.
REQ-022 CLEAR: colReset=1 SHALL be held for exactly CLR_CYCLES cycles (a counter), then the state SHALL go to GEN.
REQ-023 GEN: the watchdog counter SHALL increment each cycle; when all colDone bits are 1, the state SHALL go to SEL.
REQ-024 GEN: if the watchdog counter reaches TIMEOUT before all colDone bits are 1, the state SHALL go to FIN with error=1.
REQ-025 SEL: the block SHALL search the columns rrPtr, rrPtr+1, ... (mod NCOL) and pick the first with colEmpty=0.
REQ-026 SEL: when a column is picked, colRden for that column SHALL be driven combinationally in the same cycle, sel SHALL be latched, and the state SHALL go to READ.
REQ-027 SEL: if no column is non-empty, the state SHALL go to FIN.
REQ-028 READ: colData slice sel SHALL be registered into outData, moveCount SHALL increment, and the state SHALL go to OUT.
REQ-029 Column FIFO read latency SHALL be 1 cycle; latency from SEL to outValid SHALL be 2 cycles.
REQ-030 OUT: outValid SHALL be 1 and outData SHALL be stable until outValid=1 and outReady=1 coincide.
REQ-031 OUT: on that handshake, outValid SHALL drop the next cycle, rrPtr SHALL become (sel+1) mod NCOL, and the state SHALL go to SEL.
REQ-032 Throughput SHALL be at most one word per 3 cycles.
REQ-033 colRden SHALL be zero-hot outside SEL and never more than one-hot.
REQ-034 moveCount SHALL saturate at 255 and never wrap.
REQ-035 colDone or colEmpty bits that change while in SEL, READ or OUT SHALL only affect the next SEL search.
REQ-036 FIN SHALL hold done=1 until start or reset.

Reset
REQ-037 While reset=1 the state SHALL be IDLE, and rrPtr, sel, the counters, moveCount, error, outValid, outData and colRden SHALL be 0.
REQ-038 colReset SHALL equal reset OR (state==CLEAR), so the columns are also reset during a system reset.
REQ-039 Reset asserted in any state, including mid-handshake in OUT, SHALL abort at the next clock edge; the in-flight word SHALL be dropped.

Verification
REQ-040 Reset then start=1 for 1 cycle -> colReset=1 for exactly 2 cycles, then GEN with busy=1.
REQ-041 All colDone=1; columns 2 and 5 each hold 1 word (0xA..., 0xB...); outReady=1 -> outData 0xA then 0xB, each outValid 1 cycle, moveCount=2, then done=1.
REQ-042 Columns 0 and 7 both hold 3 words -> emitted column order 0,7,0,7,0,7 (round-robin).
REQ-043 outReady=0 for 10 cycles in OUT -> outData and outValid stable for all 10 cycles; colRden stays 0.
REQ-044 colDone=0x7F held -> error=1 and done=1 after 1023 GEN cycles; no colRden pulse.
REQ-045 Reset asserted in OUT with outValid=1 -> next cycle outValid=0, IDLE, moveCount=0, colReset=1.

Source files
------------

// File: rtl/board_arbiter.sv
// Move-generation arbiter: clears the column units, waits for them to finish, then
// drains their result FIFOs round-robin into a single ready/valid output stream.
module board_arbiter #(
    parameter int NCOL       = 8,
    parameter int W          = 160,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NCOL-1:0]   colDone,
    input  logic [NCOL-1:0]   colEmpty,
    input  logic [NCOL*W-1:0] colData,
    output logic [NCOL-1:0]   colRden,
    output logic              colReset,
    output logic              outValid,
    input  logic              outReady,
    output logic [W-1:0]      outData,
    output logic [7:0]        moveCount,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int SW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, GEN, SEL, READ, OUT, FIN} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] rr_ptr, sel, pick_idx, sel_inc, idx;
    logic [SW:0]   sum;
    logic          pick_found, all_done, clr_last, wdog_expire, handshake;
    logic [CW-1:0] clr_cnt;
    logic [TW-1:0] wdog;
    logic [7:0]    move_count;
    logic          err_q, out_valid_q;
    logic [W-1:0]  out_data_q;

    assign all_done    = &colDone;
    assign clr_last    = (clr_cnt == CW'(CLR_CYCLES - 1));
    assign wdog_expire = (wdog == TW'(TIMEOUT - 1));
    assign handshake   = out_valid_q & outReady;
    assign sel_inc     = (sel == SW'(NCOL - 1)) ? '0 : sel + 1'b1;

    // First non-empty column at or after rr_ptr, wrapping modulo NCOL
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        idx        = '0;
        for (int i = 0; i < NCOL; i++) begin
            sum = {1'b0, rr_ptr} + (SW + 1)'(i);
            if (sum >= (SW + 1)'(NCOL))
                sum = sum - (SW + 1)'(NCOL);
            idx = sum[SW-1:0];
            if (!pick_found && !colEmpty[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        colRden   = '0;
        case (state)
            IDLE, FIN: if (start) state_nxt = CLEAR;
            CLEAR:     if (clr_last) state_nxt = GEN;
            GEN: begin
                if (all_done)
                    state_nxt = SEL;
                else if (wdog_expire)
                    state_nxt = FIN;
            end
            SEL: begin
                if (pick_found) begin
                    state_nxt = READ;
                    if (!reset)
                        colRden[pick_idx] = 1'b1;
                end else begin
                    state_nxt = FIN;
                end
            end
            READ:      state_nxt = OUT;
            OUT:       if (handshake) state_nxt = SEL;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            sel         <= '0;
            clr_cnt     <= '0;
            wdog        <= '0;
            move_count  <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        rr_ptr     <= '0;
                        clr_cnt    <= '0;
                        move_count <= '0;
                        err_q      <= 1'b0;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    wdog    <= '0;
                end
                GEN: begin
                    if (!all_done) begin
                        wdog <= wdog + 1'b1;
                        if (wdog_expire)
                            err_q <= 1'b1;
                    end
                end
                SEL: if (pick_found) sel <= pick_idx;
                // FIFO data for the column read in SEL is present this cycle
                READ: begin
                    out_data_q  <= colData[sel*W +: W];
                    out_valid_q <= 1'b1;
                    if (move_count != 8'hFF)
                        move_count <= move_count + 1'b1;
                end
                OUT: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        rr_ptr      <= sel_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign colReset  = reset | (state == CLEAR);
    assign busy      = (state != IDLE) && (state != FIN);
    assign done      = (state == FIN);
    assign error     = err_q;
    assign outValid  = out_valid_q;
    assign outData   = out_data_q;
    assign moveCount = move_count;

endmodule

// File: tb/tb_board_arbiter.sv
// Directed bench for board_arbiter with behavioural 1-cycle-latency column FIFOs.
module tb_board_arbiter;

    localparam int NCOL = 8;
    localparam int W    = 160;
    localparam int DEP  = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [NCOL-1:0]   colDone = '0;
    logic [NCOL-1:0]   colEmpty = '1;
    logic [NCOL*W-1:0] colData = '0;
    logic [NCOL-1:0]   colRden;
    logic              colReset;
    logic              outValid;
    logic              outReady = 1'b1;
    logic [W-1:0]      outData;
    logic [7:0]        moveCount;
    logic              busy, done, error;

    board_arbiter #(.NCOL(NCOL), .W(W), .CLR_CYCLES(2), .TIMEOUT(1023)) dut (
        .clk(clk), .reset(reset), .start(start), .colDone(colDone),
        .colEmpty(colEmpty), .colData(colData), .colRden(colRden),
        .colReset(colReset), .outValid(outValid), .outReady(outReady),
        .outData(outData), .moveCount(moveCount), .busy(busy), .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    // Column FIFO models: a read enable at an edge presents data after that edge
    logic [W-1:0] mem [NCOL][DEP];
    int           wp [NCOL];
    int           rp [NCOL];

    always @(posedge clk) begin
        for (int c = 0; c < NCOL; c++) begin
            if (colRden[c]) begin
                colData[c*W +: W] <= mem[c][rp[c] % DEP];
                rp[c]             <= rp[c] + 1;
                colEmpty[c]       <= (rp[c] + 1 == wp[c]);
            end else begin
                colEmpty[c] <= (rp[c] == wp[c]);
            end
        end
    end

    // Output-side monitor
    int           cyc = 0;
    int           vld_n = 0, rden_n = 0, multi_rden = 0, log_n = 0;
    logic [W-1:0] log_data [256];
    int           log_cyc [256];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (outValid) vld_n <= vld_n + 1;
        if (colRden != '0) rden_n <= rden_n + 1;
        if ($countones(colRden) > 1) multi_rden <= multi_rden + 1;
        if (outValid && outReady) begin
            log_data[log_n] <= outData;
            log_cyc[log_n]  <= cyc;
            log_n           <= log_n + 1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [W-1:0] d);
        mem[c][wp[c] % DEP] = d;
        wp[c]++;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_valid(input int lim);
        int n;
        n = 0;
        while (!outValid && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    localparam logic [W-1:0] WA = {40{4'hA}};
    localparam logic [W-1:0] WB = {40{4'hB}};
    localparam logic [W-1:0] WC = {40{4'hC}};
    localparam logic [W-1:0] WD = {20{8'h3C}};

    initial begin
        int n, base, vbase, rbase;
        logic [W-1:0] exp3 [6];

        // Reset state
        step(2);
        chk("rst_colReset", W'(colReset), W'(1));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_outValid", W'(outValid), W'(0));
        chk("rst_outData", outData, W'(0));
        chk("rst_moveCount", W'(moveCount), W'(0));
        chk("rst_error", W'(error), W'(0));
        chk("rst_colRden", W'(colRden), W'(0));
        reset = 1'b0;
        step(1);
        chk("idle_colReset", W'(colReset), W'(0));

        // Start: two CLEAR cycles, then GEN
        kick();
        chk("clr1_colReset", W'(colReset), W'(1));
        chk("clr1_busy", W'(busy), W'(1));
        step(1);
        chk("clr2_colReset", W'(colReset), W'(1));
        step(1);
        chk("gen_colReset", W'(colReset), W'(0));
        chk("gen_busy", W'(busy), W'(1));
        chk("gen_done", W'(done), W'(0));
        colDone = '1;
        wait_done(20, n);
        chk("empty_done", W'(done), W'(1));
        chk("empty_busy", W'(busy), W'(0));
        chk("empty_moveCount", W'(moveCount), W'(0));

        // Columns 2 and 5 one word each
        push(2, WA);
        push(5, WB);
        step(1);
        base = log_n;
        vbase = vld_n;
        kick();
        wait_done(60, n);
        step(1);
        chk("two_done", W'(done), W'(1));
        chk("two_nwords", W'(log_n - base), W'(2));
        chk("two_word0", log_data[base], WA);
        chk("two_word1", log_data[base+1], WB);
        chk("two_vld_cycles", W'(vld_n - vbase), W'(2));
        chk("two_spacing", W'(log_cyc[base+1] - log_cyc[base]), W'(3));
        chk("two_moveCount", W'(moveCount), W'(2));

        // Columns 0 and 7 three words each: round-robin order
        exp3[0] = W'(8'h01); exp3[1] = W'(8'h71);
        exp3[2] = W'(8'h02); exp3[3] = W'(8'h72);
        exp3[4] = W'(8'h03); exp3[5] = W'(8'h73);
        for (int k = 0; k < 3; k++) begin
            push(0, exp3[2*k]);
            push(7, exp3[2*k+1]);
        end
        step(1);
        base = log_n;
        kick();
        wait_done(100, n);
        step(1);
        chk("rr_nwords", W'(log_n - base), W'(6));
        for (int k = 0; k < 6; k++)
            chk($sformatf("rr_word%0d", k), log_data[base+k], exp3[k]);
        chk("rr_moveCount", W'(moveCount), W'(6));

        // Back-pressure: data and valid hold, no further reads
        push(3, WD);
        outReady = 1'b0;
        step(1);
        kick();
        wait_valid(30);
        rbase = rden_n;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_valid%0d", k), W'(outValid), W'(1));
            chk($sformatf("bp_data%0d", k), outData, WD);
            chk($sformatf("bp_rden%0d", k), W'(colRden), W'(0));
            step(1);
        end
        outReady = 1'b1;
        step(1);
        chk("bp_valid_drop", W'(outValid), W'(0));
        wait_done(20, n);
        chk("bp_done", W'(done), W'(1));
        chk("bp_no_reads", W'(rden_n - rbase), W'(0));

        // Watchdog: one column never done; a queued word must stay unread
        colDone = 8'h7F;
        push(1, WC);
        step(1);
        rbase = rden_n;
        kick();
        wait_done(1200, n);
        chk("wd_cycles", W'(n), W'(1025));
        chk("wd_done", W'(done), W'(1));
        chk("wd_error", W'(error), W'(1));
        step(1);
        chk("wd_no_rden", W'(rden_n - rbase), W'(0));

        // Reset while a word is held in OUT
        colDone = '1;
        outReady = 1'b0;
        kick();
        chk("rst2_err_clear", W'(error), W'(0));
        wait_valid(30);
        chk("rst2_valid", W'(outValid), W'(1));
        chk("rst2_data", outData, WC);
        chk("rst2_moveCount", W'(moveCount), W'(1));
        reset = 1'b1;
        step(1);
        chk("rst2_valid_drop", W'(outValid), W'(0));
        chk("rst2_moveCount0", W'(moveCount), W'(0));
        chk("rst2_colReset", W'(colReset), W'(1));
        chk("rst2_busy", W'(busy), W'(0));
        chk("rst2_outData", outData, W'(0));
        reset = 1'b0;
        step(1);
        chk("rst2_idle_done", W'(done), W'(0));
        chk("rst2_idle_busy", W'(busy), W'(0));
        chk("rst2_idle_colReset", W'(colReset), W'(0));

        chk("never_multi_rden", W'(multi_rden), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
